multi_alarm_ctrl: RTL and testbench
===================================

Name: multi_alarm_ctrl

Overview:
- Parametrised successor to the single-alarm unit in the clock top level.
- Holds NUM_ALARMS independent BCD hh:mm alarms and compares them against the running time display on every minute change.
- Sequences ringing, snooze and dismiss through one shared FSM, with a deterministic priority queue for coincident or overlapping alarms.
- Sits beside the time display counter; its inputs come from the mode FSM and the setting registers.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..8)
IDX_W, 2, slot index width; must be >= clog2(NUM_ALARMS), minimum 1
RING_SEC, 60, seconds of ringing before automatic dismiss
SNOOZE_MIN, 5, snooze length in minutes
LED_W, 9, width of the LED indication bus

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sec_tick  in  1  one-cycle pulse per second, synchronous to clk
time_min0/time_min1/time_hour0/time_hour1  in  4 each  current time, BCD
load_en  in  1  write the load_* value into slot load_idx
load_idx  in  IDX_W  slot to write
load_min0/load_min1/load_hour0/load_hour1  in  4 each  BCD value to store
arm_en  in  NUM_ALARMS  per-slot arm mask, level-sensitive
snooze  in  1  one-cycle pulse
dismiss  in  1  one-cycle pulse
rd_idx  in  IDX_W  readback slot select
rd_min0/rd_min1/rd_hour0/rd_hour1  out  4 each  stored value of slot rd_idx, combinational
pending  out  NUM_ALARMS  per-slot triggered-but-not-dismissed flags
ringing  out  1  FSM in RING
active_idx  out  IDX_W  slot currently being serviced
led  out  LED_W  indication pattern

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: all slots 00:00; pending=0; FSM=IDLE; active_idx=0; led=0; all counters 0; the previous-time register loads the current time on the first cycle after reset, with no trigger on that cycle.
- Load: when load_en=1, slot load_idx updates on the next edge. If load_idx ≥ NUM_ALARMS, the write is ignored. A load to the active slot while in RING or SNOOZE clears its pending bit and returns the FSM to IDLE.
- Minute edge: the current {hour1,hour0,min1,min0} is registered every cycle. A minute edge occurs when the registered value differs from the input.
- Trigger: on a minute edge, every slot k with arm_en[k]=1 and a stored value equal to the new time sets pending[k]. If pending[k] is already set, nothing changes.
- FSM states:
  - IDLE: if pending≠0, go to RING with active_idx = lowest pending index, ring_cnt=0, phase=1.
  - RING: on each sec_tick, ring_cnt+1 and phase toggles.
    - dismiss: clear pending[active_idx], go to IDLE; the next pending slot starts ringing one cycle later.
    - snooze: go to SNOOZE with snz_cnt = SNOOZE_MIN*60.
    - ring_cnt reaching RING_SEC: same as dismiss.
  - SNOOZE: snz_cnt decrements on each sec_tick. At 0, go to RING with ring_cnt=0 and phase=1. dismiss in SNOOZE clears pending[active_idx] and goes to IDLE.
- Precedence: dismiss and snooze in the same cycle resolve to dismiss. snooze and dismiss in IDLE are ignored.
- Disarm: arm_en[active_idx] falling while in RING or SNOOZE clears that pending bit and returns to IDLE. arm_en falling on a non-active slot clears that slot's pending bit.
- LED: IDLE gives 0. RING gives {LED_W{phase}}. SNOOZE gives only led[LED_W-1]=1.
- Counters: ring_cnt width is clog2(RING_SEC+1); snz_cnt width is clog2(SNOOZE_MIN*60+1). No wrap is reachable.
- Comparison: pure BCD equality. Invalid BCD inputs are stored and compared as-is, without correction.

Optional Feature:
- Macro: MULTI_ALARM_SNOOZE_LIMIT_EN.
- Defined:
  - A per-service snooze counter (2 bits) allows at most 3 snoozes.
  - A 4th snooze pulse is ignored, and the alarm stays in RING until dismiss or timeout.
  - The counter clears when the active slot leaves service.
- Undefined: unlimited snoozes, and no snooze-counter logic is present.

Test Plan:
- Reset, then load slot 2 = 07:30 with arm_en=4'b0100; time steps 07:29 to 07:30 → pending=4'b0100 one cycle after the edge; ringing=1 and active_idx=2 the cycle after; led toggles 1FF/000 per sec_tick.
- Slots 0 and 3 both 12:00 and armed; time reaches 12:00 → pending=4'b1001, active_idx=0. dismiss → IDLE, then RING with active_idx=3.
- Ringing slot 1; snooze pulse → led=9'h100. After 300 sec_ticks → RING again. dismiss and snooze asserted in the same cycle → IDLE, pending[1]=0.
- Ringing with no input → after 60 sec_ticks, ringing=0 and pending cleared.
- Ringing slot 0, arm_en[0] dropped → IDLE next cycle. Repeat, asserting rst_n=0 mid-SNOOZE → all outputs at reset values immediately.
- With MULTI_ALARM_SNOOZE_LIMIT_EN: 4 snoozes → the 4th is ignored and the alarm stays in RING. Without the macro → 4 snoozes all accepted.

Source files
------------

// File: rtl/multi_alarm_if.sv
// multi_alarm_if: time, setting, control and indication bundle for the
// multi-slot alarm controller (master = mode FSM / settings, slave = ctrl).
interface multi_alarm_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int LED_W      = 9
);
  logic                  sec_tick;
  logic [3:0]            time_min0;
  logic [3:0]            time_min1;
  logic [3:0]            time_hour0;
  logic [3:0]            time_hour1;
  logic                  load_en;
  logic [IDX_W-1:0]      load_idx;
  logic [3:0]            load_min0;
  logic [3:0]            load_min1;
  logic [3:0]            load_hour0;
  logic [3:0]            load_hour1;
  logic [NUM_ALARMS-1:0] arm_en;
  logic                  snooze;
  logic                  dismiss;
  logic [IDX_W-1:0]      rd_idx;
  logic [3:0]            rd_min0;
  logic [3:0]            rd_min1;
  logic [3:0]            rd_hour0;
  logic [3:0]            rd_hour1;
  logic [NUM_ALARMS-1:0] pending;
  logic                  ringing;
  logic [IDX_W-1:0]      active_idx;
  logic [LED_W-1:0]      led;

  modport master (
    output sec_tick,
    output time_min0, time_min1,
    output time_hour0, time_hour1,
    output load_en, load_idx,
    output load_min0, load_min1,
    output load_hour0, load_hour1,
    output arm_en, snooze, dismiss,
    output rd_idx,
    input  rd_min0, rd_min1,
    input  rd_hour0, rd_hour1,
    input  pending, ringing,
    input  active_idx, led
  );

  modport slave (
    input  sec_tick,
    input  time_min0, time_min1,
    input  time_hour0, time_hour1,
    input  load_en, load_idx,
    input  load_min0, load_min1,
    input  load_hour0, load_hour1,
    input  arm_en, snooze, dismiss,
    input  rd_idx,
    output rd_min0, rd_min1,
    output rd_hour0, rd_hour1,
    output pending, ringing,
    output active_idx, led
  );
endinterface

// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: NUM_ALARMS BCD hh:mm alarms sharing one ring/snooze FSM.
// Define MULTI_ALARM_SNOOZE_LIMIT_EN to cap snoozes at 3 per service.
module multi_alarm_ctrl #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int LED_W      = 9
) (
  input logic          clk,
  input logic          rst_n,
  multi_alarm_if.slave bus
);

  localparam int SNZ_SEC = SNOOZE_MIN * 60;
  localparam int RC_W = $clog2(RING_SEC + 1);
  localparam int SC_W = (SNZ_SEC > 0) ? $clog2(SNZ_SEC + 1) : 1;
  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SEC - 1);
  localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);
  localparam logic [SC_W-1:0] SNZ_LOAD  = SC_W'(SNZ_SEC);
  localparam logic [SC_W-1:0] SC_ONE    = SC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNOOZE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_slot [NUM_ALARMS];
  logic [15:0]           r_prev;
  logic                  r_started;
  logic [NUM_ALARMS-1:0] r_pending;
  logic [NUM_ALARMS-1:0] r_arm_prev;
  logic [IDX_W-1:0]      r_active;
  logic [RC_W-1:0]       r_ring_cnt;
  logic [SC_W-1:0]       r_snz_cnt;
  logic                  r_phase;

  logic [15:0]           w_now;
  logic [15:0]           w_load_val;
  logic [15:0]           w_rd;
  logic                  w_edge;
  logic [NUM_ALARMS-1:0] w_match;
  logic [NUM_ALARMS-1:0] w_act_oh;
  logic [NUM_ALARMS-1:0] w_load_oh;
  logic [NUM_ALARMS-1:0] w_fall;
  logic [NUM_ALARMS-1:0] w_pend_set;
  logic [NUM_ALARMS-1:0] w_pend_clr;
  logic [IDX_W-1:0]      w_first;
  logic                  w_in_svc;
  logic                  w_load_act;
  logic                  w_fall_act;
  logic                  w_kill;
  logic                  w_timeout;
  logic                  w_snz_done;
  logic                  w_snz_ok;

  assign w_now = {bus.time_hour1, bus.time_hour0,
                  bus.time_min1, bus.time_min0};
  assign w_load_val = {bus.load_hour1, bus.load_hour0,
                       bus.load_min1, bus.load_min0};

  // Descending scan so the lowest pending slot wins.
  always_comb begin
    w_match   = '0;
    w_act_oh  = '0;
    w_load_oh = '0;
    w_first   = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      w_match[k]   = (r_slot[k] == w_now);
      w_act_oh[k]  = (r_active == IDX_W'(k));
      w_load_oh[k] = bus.load_en &&
                     (bus.load_idx == IDX_W'(k));
      if (r_pending[k]) w_first = IDX_W'(k);
    end
  end

  assign w_edge     = r_started && (r_prev != w_now);
  assign w_fall     = r_arm_prev & ~bus.arm_en;
  assign w_in_svc   = (r_state != S_IDLE);
  assign w_load_act = |(w_load_oh & w_act_oh);
  assign w_fall_act = |(w_fall & w_act_oh);
  assign w_kill     = w_in_svc &&
                      (bus.dismiss || w_load_act || w_fall_act);
  assign w_timeout  = (r_state == S_RING) && bus.sec_tick &&
                      (r_ring_cnt == RING_LAST);
  assign w_snz_done = (r_snz_cnt == '0) ||
                      (bus.sec_tick && (r_snz_cnt == SC_ONE));
  assign w_pend_set = w_edge ? (bus.arm_en & w_match) : '0;
  assign w_pend_clr = w_fall |
                      ((w_kill || w_timeout) ? w_act_oh : '0);

`ifdef MULTI_ALARM_SNOOZE_LIMIT_EN
  logic [1:0] r_snz_used;

  assign w_snz_ok = (r_snz_used != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snz_used <= '0;
    end else if (w_state_nxt == S_IDLE) begin
      r_snz_used <= '0;
    end else if (r_state == S_RING &&
                 w_state_nxt == S_SNOOZE) begin
      r_snz_used <= r_snz_used + 2'd1;
    end
  end
`else
  assign w_snz_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (|r_pending) w_state_nxt = S_RING;
      end
      S_RING: begin
        if (w_kill || w_timeout)
          w_state_nxt = S_IDLE;
        else if (bus.snooze && w_snz_ok)
          w_state_nxt = S_SNOOZE;
      end
      S_SNOOZE: begin
        if (w_kill)          w_state_nxt = S_IDLE;
        else if (w_snz_done) w_state_nxt = S_RING;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ringing = 1'b0;
    bus.led     = '0;
    unique case (r_state)
      S_RING: begin
        bus.ringing = 1'b1;
        bus.led     = {LED_W{r_phase}};
      end
      S_SNOOZE: bus.led[LED_W-1] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_started  <= 1'b0;
      r_pending  <= '0;
      r_arm_prev <= '0;
      r_active   <= '0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_prev     <= w_now;
      r_started  <= 1'b1;
      r_arm_prev <= bus.arm_en;
      r_pending  <= (r_pending & ~w_pend_clr) | w_pend_set;
      if (r_state == S_IDLE && w_state_nxt == S_RING)
        r_active <= w_first;
      if (r_state != S_RING && w_state_nxt == S_RING) begin
        r_ring_cnt <= '0;
        r_phase    <= 1'b1;
      end else if (r_state == S_RING && bus.sec_tick) begin
        r_ring_cnt <= r_ring_cnt + RC_ONE;
        r_phase    <= ~r_phase;
      end
      if (r_state == S_RING && w_state_nxt == S_SNOOZE)
        r_snz_cnt <= SNZ_LOAD;
      else if (r_state == S_SNOOZE && bus.sec_tick &&
               r_snz_cnt != '0)
        r_snz_cnt <= r_snz_cnt - SC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ALARMS; k++)
        r_slot[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++)
        if (w_load_oh[k]) r_slot[k] <= w_load_val;
    end
  end

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NUM_ALARMS; k++)
      if (bus.rd_idx == IDX_W'(k)) w_rd = r_slot[k];
  end

  assign {bus.rd_hour1, bus.rd_hour0,
          bus.rd_min1, bus.rd_min0} = w_rd;
  assign bus.pending    = r_pending;
  assign bus.active_idx = r_active;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: behavioural alarm model feeds an output-change
// scoreboard; directed scenarios then randomized traffic.
module tb_multi_alarm_ctrl;
  localparam int NA = 4;
  localparam int IW = 2;
  localparam int RS = 60;
  localparam int SM = 5;
  localparam int LW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_alarm_if #(.NUM_ALARMS(NA), .IDX_W(IW), .LED_W(LW)) bus ();

  multi_alarm_ctrl #(
    .NUM_ALARMS(NA), .IDX_W(IW), .RING_SEC(RS),
    .SNOOZE_MIN(SM), .LED_W(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [NA-1:0] pend;
    logic          ring;
    logic [IW-1:0] act;
    logic [LW-1:0] led;
    logic [15:0]   rd;
  } obs_t;

  typedef struct {
    obs_t o;
    int   stamp;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: service described by seconds rung / seconds left.
  logic [15:0]   m_slot [NA];
  logic [15:0]   m_prev;
  bit            m_have_prev;
  logic [NA-1:0] m_pend;
  logic [NA-1:0] m_arm_prev;
  int            m_active;
  bit            m_busy;
  bit            m_snoozing;
  bit            m_phase;
  int            m_ring_s;
  int            m_snz_left;
  int            m_snz_used;
  obs_t          m_last;

  function automatic obs_t model_obs();
    obs_t o;
    o.pend = m_pend;
    o.ring = m_busy && !m_snoozing;
    o.act  = IW'(m_active);
    if (!m_busy)         o.led = '0;
    else if (m_snoozing) o.led = LW'(1) << (LW - 1);
    else                 o.led = {LW{m_phase}};
    o.rd = (int'(bus.rd_idx) < NA) ? m_slot[bus.rd_idx] : 16'h0;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pend = bus.pending;
    o.ring = bus.ringing;
    o.act  = bus.active_idx;
    o.led  = bus.led;
    o.rd   = {bus.rd_hour1, bus.rd_hour0, bus.rd_min1, bus.rd_min0};
    return o;
  endfunction

  function automatic bit snooze_allowed();
`ifdef MULTI_ALARM_SNOOZE_LIMIT_EN
    return m_snz_used < 3;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NA; k++) m_slot[k] = '0;
    m_prev = '0; m_have_prev = 0; m_pend = '0; m_arm_prev = '0;
    m_active = 0; m_busy = 0; m_snoozing = 0; m_phase = 0;
    m_ring_s = 0; m_snz_left = 0; m_snz_used = 0;
    m_last = '0;
  endtask

  task automatic model_step();
    logic [15:0]   now;
    logic [NA-1:0] hit;
    logic [NA-1:0] fell;
    logic [NA-1:0] drop;
    bit            end_svc;
    obs_t          o;
    now = {bus.time_hour1, bus.time_hour0, bus.time_min1, bus.time_min0};
    hit = '0;
    if (m_have_prev && now != m_prev)
      for (int k = 0; k < NA; k++)
        if (bus.arm_en[k] && m_slot[k] == now) hit[k] = 1'b1;
    fell = m_arm_prev & ~bus.arm_en;
    drop = fell;
    end_svc = 0;
    if (!m_busy) begin
      if (m_pend != 0) begin
        for (int k = NA - 1; k >= 0; k--)
          if (m_pend[k]) m_active = k;
        m_busy = 1; m_snoozing = 0; m_ring_s = 0; m_phase = 1;
      end
    end else if (bus.dismiss || fell[m_active] ||
                 (bus.load_en && int'(bus.load_idx) == m_active)) begin
      end_svc = 1;
    end else if (!m_snoozing) begin
      if (bus.sec_tick && m_ring_s + 1 >= RS) begin
        end_svc = 1;
      end else if (bus.snooze && snooze_allowed()) begin
        m_snoozing = 1; m_snz_left = SM * 60; m_snz_used++;
      end else if (bus.sec_tick) begin
        m_ring_s++; m_phase = !m_phase;
      end
    end else begin
      if (bus.sec_tick && m_snz_left > 0) m_snz_left--;
      if (m_snz_left == 0) begin
        m_snoozing = 0; m_ring_s = 0; m_phase = 1;
      end
    end
    if (end_svc) begin
      drop[m_active] = 1'b1;
      m_busy = 0; m_snoozing = 0; m_snz_used = 0;
    end
    m_pend = (m_pend & ~drop) | hit;
    if (bus.load_en && int'(bus.load_idx) < NA)
      m_slot[bus.load_idx] = {bus.load_hour1, bus.load_hour0,
                              bus.load_min1, bus.load_min0};
    m_prev = now; m_have_prev = 1; m_arm_prev = bus.arm_en;
    o = model_obs();
    if (o != m_last) begin
      exp_q.push_back('{o: o, stamp: cyc + 1});
      m_last = o;
    end
  endtask

  // Monitor: every observed output change consumes one expected entry.
  obs_t mon_prev = '0;
  always begin
    obs_t cur;
    exp_t e;
    @(posedge clk);
    #2;
    cur = dut_obs();
    if (!rst_n) begin
      mon_prev = cur;
    end else if (cur != mon_prev) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected cyc=%0d got %h want no change",
                 cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.o != cur || e.stamp != cyc) begin
          n_bad++;
          $display("FAIL sb_change cyc=%0d got %h want %h at cyc %0d",
                   cyc, cur, e.o, e.stamp);
        end
      end
      mon_prev = cur;
    end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
      n_cmp++;
      n_bad++;
      e = exp_q.pop_front();
      $display("FAIL sb_missed cyc=%0d got %h want %h", cyc, cur, e.o);
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    bus.load_en = 0; bus.snooze = 0; bus.dismiss = 0; bus.sec_tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_tick = 1;
      step();
    end
  endtask

  task automatic set_time(input logic [15:0] t);
    {bus.time_hour1, bus.time_hour0, bus.time_min1, bus.time_min0} = t;
    step();
  endtask

  task automatic load(input int idx, input logic [15:0] v);
    bus.load_en = 1;
    bus.load_idx = IW'(idx);
    {bus.load_hour1, bus.load_hour0, bus.load_min1, bus.load_min0} = v;
    step();
  endtask

  task automatic pulse(input bit snz, input bit dis);
    bus.snooze = snz;
    bus.dismiss = dis;
    step();
  endtask

  task automatic reset_now(input string tag);
    rst_n = 0;
    #1;
    check({tag, "_pending"}, 32'(bus.pending), 0);
    check({tag, "_ringing"}, 32'(bus.ringing), 0);
    check({tag, "_led"}, 32'(bus.led), 0);
    check({tag, "_active"}, 32'(bus.active_idx), 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] pool [5];

  initial begin
    pool[0] = 16'h0730; pool[1] = 16'h1200; pool[2] = 16'h0A3F;
    pool[3] = 16'h2359; pool[4] = 16'h0001;
    bus.sec_tick = 0; bus.load_en = 0; bus.load_idx = '0;
    {bus.load_hour1, bus.load_hour0, bus.load_min1, bus.load_min0} = '0;
    {bus.time_hour1, bus.time_hour0, bus.time_min1, bus.time_min0} = '0;
    bus.arm_en = '0; bus.snooze = 0; bus.dismiss = 0; bus.rd_idx = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_now("rst0");

    // slot 2 at 07:30
    load(2, 16'h0730);
    bus.rd_idx = 2;
    bus.arm_en = 4'b0100;
    set_time(16'h0729);
    check("rd_slot2", 32'({bus.rd_hour1, bus.rd_hour0, bus.rd_min1,
                           bus.rd_min0}), 32'h0730);
    set_time(16'h0730);
    check("s1_pending", 32'(bus.pending), 32'b0100);
    check("s1_not_yet", 32'(bus.ringing), 0);
    step();
    check("s1_ringing", 32'(bus.ringing), 1);
    check("s1_active", 32'(bus.active_idx), 2);
    check("s1_led_on", 32'(bus.led), 32'h1FF);
    ticks(1);
    check("s1_led_off", 32'(bus.led), 32'h000);
    ticks(1);
    check("s1_led_on2", 32'(bus.led), 32'h1FF);
    pulse(0, 1);

    // coincident slots 0 and 3
    load(0, 16'h1200);
    load(3, 16'h1200);
    bus.arm_en = 4'b1001;
    set_time(16'h1159);
    set_time(16'h1200);
    check("s2_pending", 32'(bus.pending), 32'b1001);
    step();
    check("s2_active0", 32'(bus.active_idx), 0);
    pulse(0, 1);
    check("s2_idle", 32'(bus.ringing), 0);
    check("s2_pend3", 32'(bus.pending), 32'b1000);
    step();
    check("s2_active3", 32'(bus.active_idx), 3);
    check("s2_ring3", 32'(bus.ringing), 1);
    pulse(0, 1);

    // snooze on slot 1
    load(1, 16'h0645);
    bus.arm_en = 4'b0010;
    set_time(16'h0644);
    set_time(16'h0645);
    step();
    pulse(1, 0);
    check("s3_snz_led", 32'(bus.led), 32'h100);
    ticks(SM * 60 - 1);
    check("s3_still_snz", 32'(bus.ringing), 0);
    ticks(1);
    check("s3_reringing", 32'(bus.ringing), 1);
    pulse(1, 1);
    check("s3_both_idle", 32'(bus.ringing), 0);
    check("s3_pend_clr", 32'(bus.pending), 0);

    // timeout
    set_time(16'h0646);
    set_time(16'h0645);
    step();
    ticks(RS - 1);
    check("s4_before_to", 32'(bus.ringing), 1);
    ticks(1);
    check("s4_timeout", 32'(bus.ringing), 0);
    check("s4_pend", 32'(bus.pending), 0);

    // disarm, then reset mid-snooze
    load(0, 16'h2359);
    bus.arm_en = 4'b0001;
    set_time(16'h2358);
    set_time(16'h2359);
    step();
    check("s5_ring0", 32'(bus.ringing), 1);
    bus.arm_en = 4'b0000;
    step();
    check("s5_disarm", 32'(bus.ringing), 0);
    check("s5_disarm_p", 32'(bus.pending), 0);
    bus.arm_en = 4'b0001;
    set_time(16'h2358);
    set_time(16'h2359);
    step();
    pulse(1, 0);
    ticks(10);
    check("s5_in_snz", 32'(bus.led), 32'h100);
    reset_now("rst1");
    check("rd_after_rst", 32'({bus.rd_hour1, bus.rd_hour0, bus.rd_min1,
                               bus.rd_min0}), 0);

    // four snoozes
    load(3, 16'h0915);
    bus.arm_en = 4'b1000;
    set_time(16'h0914);
    set_time(16'h0915);
    step();
    for (int i = 0; i < 3; i++) begin
      pulse(1, 0);
      check("s6_snz_ok", 32'(bus.led), 32'h100);
      ticks(SM * 60);
      check("s6_back", 32'(bus.ringing), 1);
    end
    pulse(1, 0);
`ifdef MULTI_ALARM_SNOOZE_LIMIT_EN
    check("s6_4th_ign", 32'(bus.ringing), 1);
    check("s6_4th_led", 32'(bus.led), 32'h1FF);
`else
    check("s6_4th_acc", 32'(bus.ringing), 0);
    check("s6_4th_led", 32'(bus.led), 32'h100);
`endif
    pulse(0, 1);
    check("s6_done", 32'(bus.ringing), 0);

    // randomized traffic
    for (int i = 0; i < 15000; i++) begin
      bus.sec_tick = ($urandom_range(0, 3) == 0);
      bus.rd_idx = IW'($urandom_range(0, NA - 1));
      if ($urandom_range(0, 39) == 0)
        {bus.time_hour1, bus.time_hour0, bus.time_min1,
         bus.time_min0} = pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 199) == 0) begin
        bus.load_en = 1;
        bus.load_idx = IW'($urandom_range(0, NA - 1));
        {bus.load_hour1, bus.load_hour0, bus.load_min1,
         bus.load_min0} = pool[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 149) == 0)
        bus.arm_en[$urandom_range(0, NA - 1)] ^= 1'b1;
      bus.snooze = ($urandom_range(0, 99) == 0);
      bus.dismiss = ($urandom_range(0, 299) == 0);
      step();
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
